// File: rtl/csa8_bist.sv
// csa8_bist: stimulus driver and response checker for an 8-bit adder.
// Optional: define CSA8_BIST_STOP_ON_FAIL_EN to end a run on the first mismatch.
module csa8_bist #(
  parameter int          LAT         = 1,
  parameter int          NUM_VECTORS = 256,
  parameter logic [7:0]  SEED        = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  input  logic [7:0] dut_sum,
  input  logic       dut_cout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [8:0] vec_count,
  output logic [7:0] fail_a,
  output logic [7:0] fail_b
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    CHECK,
    FIN
  } state_t;

  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [7:0] SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [3:0] WAIT_INIT = 4'(LAT - 1);
  localparam logic [8:0] LAST_VEC  = 9'(NUM_VECTORS - 1);

  state_t     state;
  logic [7:0] lfsr;
  logic [3:0] wcnt;

  logic [8:0] expected;
  logic       mismatch;
  logic [7:0] err_next;
  logic [7:0] lfsr_next;
  logic       last_vec;
  logic       stop_now;

  // Reference add, error tally and LFSR step for the current vector.
  always_comb begin
    expected  = {1'b0, op_a} + {1'b0, op_b};
    mismatch  = (expected != {dut_cout, dut_sum});
    err_next  = err_count;
    if (mismatch && (err_count != 8'hFF))
      err_next = err_count + 8'd1;
    lfsr_next = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
    last_vec  = (vec_count == LAST_VEC);
`ifdef CSA8_BIST_STOP_ON_FAIL_EN
    stop_now  = mismatch;
`else
    stop_now  = 1'b0;
`endif
  end

  // Sequencer: drive, wait for the adder, check, repeat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= SEED_EFF;
      wcnt      <= 4'd0;
      op_a      <= 8'd0;
      op_b      <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 8'd0;
      vec_count <= 9'd0;
      fail_a    <= 8'd0;
      fail_b    <= 8'd0;
    end else begin
      unique case (state)
        IDLE, FIN: begin
          if (start) begin
            state     <= DRIVE;
            lfsr      <= SEED_EFF;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 8'd0;
            vec_count <= 9'd0;
            fail_a    <= 8'd0;
            fail_b    <= 8'd0;
          end
        end
        DRIVE: begin
          op_a  <= lfsr;
          op_b  <= vec_count[7:0];
          lfsr  <= lfsr_next;
          wcnt  <= WAIT_INIT;
          state <= WAIT;
        end
        WAIT: begin
          if (wcnt == 4'd0)
            state <= CHECK;
          else
            wcnt <= wcnt - 4'd1;
        end
        CHECK: begin
          err_count <= err_next;
          vec_count <= vec_count + 9'd1;
          if (mismatch && (err_count == 8'd0)) begin
            fail_a <= op_a;
            fail_b <= op_b;
          end
          if (last_vec || stop_now) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 8'd0);
          end else begin
            state <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa8_bist.sv
// tb_csa8_bist: randomized fault-mode runs of csa8_bist against
// a reference model of the run outcome.
module tb_csa8_bist;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start_s = 1'b0;

  logic [7:0] op_a, op_b, dut_sum, err_count, fail_a, fail_b;
  logic       dut_cout, busy, done, pass;
  logic [8:0] vec_count;

  logic [7:0] s_op_a, s_op_b, s_sum, s_err, s_fa, s_fb;
  logic       s_cout, s_busy, s_done, s_pass;
  logic [8:0] s_vec;

  int mode = 0;
  int checks = 0;
  int fails = 0;

  logic [8:0] raw;
  assign raw = {1'b0, op_a} + {1'b0, op_b};

  // Adder under test with selectable fault.
  always_comb begin
    dut_sum  = raw[7:0];
    dut_cout = raw[8];
    if (mode == 1) dut_cout = 1'b0;
    if (mode == 2) dut_sum = ~raw[7:0];
  end

  assign {s_cout, s_sum} = {1'b0, s_op_a} + {1'b0, s_op_b};

  always #5 clk = ~clk;

  csa8_bist u_dut (
    .clk(clk), .rst(rst), .start(start),
    .op_a(op_a), .op_b(op_b),
    .dut_sum(dut_sum), .dut_cout(dut_cout),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .vec_count(vec_count),
    .fail_a(fail_a), .fail_b(fail_b)
  );

  csa8_bist #(.LAT(4), .NUM_VECTORS(10)) u_small (
    .clk(clk), .rst(rst), .start(start_s),
    .op_a(s_op_a), .op_b(s_op_b),
    .dut_sum(s_sum), .dut_cout(s_cout),
    .busy(s_busy), .done(s_done), .pass(s_pass),
    .err_count(s_err), .vec_count(s_vec),
    .fail_a(s_fa), .fail_b(s_fb)
  );

  int ma [256];
  int mb [256];
  int got_a [256];
  int got_b [256];
  int e_err, e_vec, e_fa, e_fb;
  bit e_pass;

  // Expected outcome of a run, from the vector rules and fault mode.
  task automatic model(input int m, input int nv);
    int x, errs, s;
    bit bad;
    x = 'hA5;
    errs = 0;
    e_fa = 0;
    e_fb = 0;
    e_vec = nv;
    for (int k = 0; k < nv; k++) begin
      ma[k] = x;
      mb[k] = k % 256;
      s = ma[k] + mb[k];
      bad = (m == 1) ? (s > 255) : (m == 2);
      if (bad) begin
        if (errs == 0) begin
          e_fa = ma[k];
          e_fb = mb[k];
        end
        errs++;
      end
`ifdef CSA8_BIST_STOP_ON_FAIL_EN
      if (bad) begin
        e_vec = k + 1;
        break;
      end
`endif
      x = (x % 2 == 1) ? ((x / 2) ^ 'hB8) : (x / 2);
    end
    e_err = (errs > 255) ? 255 : errs;
    e_pass = (errs == 0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'($urandom);
      start_s = 1'($urandom);
      mode = int'($urandom_range(0, 2));
    end
    #1;
    checks++;
    if ({op_a, op_b, busy, done, pass, err_count,
         vec_count, fail_a, fail_b} !== '0) begin
      fails++;
      $display("FAIL reset_outs got a=%h b=%h busy=%b done=%b pass=%b err=%0d vec=%0d fa=%h fb=%h want all 0",
               op_a, op_b, busy, done, pass, err_count, vec_count, fail_a, fail_b);
    end
    checks++;
    if ({s_op_a, s_op_b, s_busy, s_done, s_pass, s_err,
         s_vec, s_fa, s_fb} !== '0) begin
      fails++;
      $display("FAIL reset_small got busy=%b done=%b vec=%0d want all 0",
               s_busy, s_done, s_vec);
    end
    @(negedge clk);
    start = 1'b0;
    start_s = 1'b0;
    mode = 0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_main(input int m, input string tag,
                          input bit poke);
    int n, bc, badv;
    bit tmo;
    model(m, 256);
    mode = m;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    bc = busy ? 1 : 0;
    n = 0;
    tmo = 1'b1;
    while (n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      if ((n - 1) % 3 == 0 && (n - 1) / 3 < 256) begin
        got_a[(n - 1) / 3] = int'(op_a);
        got_b[(n - 1) / 3] = int'(op_b);
      end
      if (poke && n == 50) start = 1'b1;
      if (poke && n == 51) start = 1'b0;
      if (done) begin
        tmo = 1'b0;
        break;
      end
      bc += busy ? 1 : 0;
    end
    checks++;
    if (tmo || n != e_vec * 3) begin
      fails++;
      $display("FAIL %s cycles got %0d want %0d", tag, n, e_vec * 3);
    end
    checks++;
    if (bc != e_vec * 3 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s busy got %0d cycles, end=%b want %0d, 0",
               tag, bc, busy, e_vec * 3);
    end
    checks++;
    if (pass !== e_pass) begin
      fails++;
      $display("FAIL %s pass got %b want %b", tag, pass, e_pass);
    end
    checks++;
    if (int'(err_count) != e_err) begin
      fails++;
      $display("FAIL %s err_count got %0d want %0d", tag, err_count, e_err);
    end
    checks++;
    if (int'(vec_count) != e_vec) begin
      fails++;
      $display("FAIL %s vec_count got %0d want %0d", tag, vec_count, e_vec);
    end
    checks++;
    if (int'(fail_a) != e_fa || int'(fail_b) != e_fb) begin
      fails++;
      $display("FAIL %s fail_ab got %h/%h want %h/%h",
               tag, fail_a, fail_b, e_fa, e_fb);
    end
    checks++;
    if (got_a[0] != 'hA5 || got_b[0] != 0) begin
      fails++;
      $display("FAIL %s vec0 got %h/%h want a5/00", tag, got_a[0], got_b[0]);
    end
    badv = 0;
    for (int k = 0; k < e_vec; k++)
      if (got_a[k] != ma[k] || got_b[k] != mb[k]) badv++;
    checks++;
    if (badv != 0) begin
      fails++;
      $display("FAIL %s operands got %0d wrong vectors (v1 %h/%h) want 0 (v1 %h/%h)",
               tag, badv, got_a[1], got_b[1], ma[1], mb[1]);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || int'(vec_count) != e_vec) begin
      fails++;
      $display("FAIL %s hold got done=%b vec=%0d want 1/%0d",
               tag, done, vec_count, e_vec);
    end
    mode = 0;
  endtask

  task automatic test_reset_mid;
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({op_a, op_b, busy, done, pass, err_count,
         vec_count, fail_a, fail_b} !== '0) begin
      fails++;
      $display("FAIL mid_reset got a=%h b=%h busy=%b vec=%0d want all 0",
               op_a, op_b, busy, vec_count);
    end
    @(negedge clk);
    rst = 1'b0;
    run_main(0, "after_rst", 1'b0);
  endtask

  task automatic test_lat4;
    int n;
    bit tmo;
    model(0, 10);
    @(negedge clk);
    start_s = 1'b1;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    n = 0;
    tmo = 1'b1;
    while (n < 500) begin
      @(posedge clk);
      #1;
      n++;
      if (s_done) begin
        tmo = 1'b0;
        break;
      end
    end
    checks++;
    if (tmo || n != 60) begin
      fails++;
      $display("FAIL lat4_cycles got %0d want 60", n);
    end
    checks++;
    if (s_pass !== 1'b1 || int'(s_vec) != e_vec || s_err !== 8'd0) begin
      fails++;
      $display("FAIL lat4_result got pass=%b vec=%0d err=%0d want 1/%0d/0",
               s_pass, s_vec, s_err, e_vec);
    end
    checks++;
    if (int'(s_op_a) != ma[9] || int'(s_op_b) != mb[9]) begin
      fails++;
      $display("FAIL lat4_last got %h/%h want %h/%h",
               s_op_a, s_op_b, ma[9], mb[9]);
    end
  endtask

  initial begin
    test_reset();
    run_main(0, "golden", 1'b0);
    run_main(1, "cout_stuck0", 1'b0);
    run_main(2, "sum_inverted", 1'b0);
    run_main(0, "start_poke", 1'b1);
    test_reset_mid();
    test_lat4();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/csa8_bist.md
Name: csa8_bist

Overview:
- Self-checking stimulus driver and response checker for the 8-bit carry-select adder's pin interface.
- It drives operand A (`ui_in` side) and operand B (`uio_in` side), then samples sum (`uo_out`) and carry-out (`uio_out[7]`).
- Each result is compared against an internal 9-bit reference add.
- Passing and failing vectors are tallied. Used for on-chip BIST and as a reusable bench component.

Parameters:
- `LAT`, default 1: cycles between operand update and result sample. Legal range 1..15.
- `NUM_VECTORS`, default 256: vectors per run. Legal range 1..256.
- `SEED`, default 8'hA5: LFSR seed for operand A. A value of 0 is replaced by 8'h01.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous reset, active-high
- `start`  in  1  begin a run; sampled in IDLE or DONE only
- `op_a`  out  8  operand A to adder (registered)
- `op_b`  out  8  operand B to adder (registered)
- `dut_sum`  in  8  adder sum
- `dut_cout`  in  1  adder carry-out
- `busy`  out  1  run in progress
- `done`  out  1  run complete; held until next start or reset
- `pass`  out  1  valid when `done`; 1 = zero mismatches
- `err_count`  out  8  mismatch count, saturates at 255
- `vec_count`  out  9  vectors checked this run
- `fail_a`  out  8  `op_a` of first mismatching vector
- `fail_b`  out  8  `op_b` of first mismatching vector

Behaviour:
- Clocking: one clock `clk`. Reset is asynchronous and active-high on `rst`; the polarity and synchronicity are fixed.
- Reset: all outputs are 0; FSM goes to IDLE; LFSR is loaded with `SEED`. Asserting `rst` mid-run aborts the run and clears everything. No partial results survive.
- FSM states and transitions:
  - IDLE →(start) DRIVE.
  - DRIVE (1 cycle) → WAIT.
  - WAIT (`LAT` cycles) → CHECK.
  - CHECK (1 cycle) → DRIVE if more vectors remain, else DONE.
  - DONE →(start) DRIVE.
- Run start: on each start, the LFSR is reloaded with `SEED`; `err_count`, `vec_count`, `fail_a`, `fail_b` and `pass` are cleared; `done` deasserts.
- `busy` is 1 in DRIVE, WAIT and CHECK. `start` is ignored while busy.
- Operands:
  - In DRIVE, `op_a` ← LFSR value and `op_b` ← vector index[7:0].
  - Vector 0 is therefore (`SEED`, 0x00) and vector 1 is (next LFSR, 0x01).
  - The LFSR is a Galois 8-bit LFSR, polynomial x^8+x^6+x^5+x^4+1, advanced once per DRIVE after use. It never reaches 0.
  - Operands hold stable through WAIT and CHECK.
- Check:
  - In CHECK, the expected value is `{1'b0,op_a}+{1'b0,op_b}` (9 bits). It is compared with `{dut_cout,dut_sum}`.
  - On mismatch, `err_count` increments unless it is already 255.
  - If this is the first mismatch of the run, `fail_a`/`fail_b` capture the operands.
  - `vec_count` increments every CHECK.
- Timing: each vector takes exactly `LAT`+2 cycles. A full default run is 256×3 = 768 cycles from the cycle after start to DONE entry.
- On DONE entry, `done`=1, and `pass`=1 iff `err_count`==0. Outputs hold in DONE; `op_a`/`op_b` keep the last vector.
- If `start` and `rst` are asserted together, reset wins.

Optional Feature:
- Macro: `CSA8_BIST_STOP_ON_FAIL_EN`.
- Defined: on the first mismatch, CHECK goes directly to DONE with `pass`=0, `err_count`=1, and `vec_count` = index of the failing vector + 1.
- Undefined: all `NUM_VECTORS` vectors always run, regardless of mismatches.

Test Plan:
- Reset: assert `rst` with random inputs → all outputs 0; `busy`=0, `done`=0.
- Golden adder model with `LAT`=1: pulse `start` → `busy` high for 768 cycles, then `done`=1, `pass`=1, `err_count`=0, `vec_count`=256. The first two driven vectors are (0xA5,0x00) and (LFSR(0xA5),0x01).
- Model with `dut_cout` stuck 0, macro undefined → `err_count` equals the number of the 256 vectors whose op_a+op_b > 255. `fail_a`/`fail_b` match the first such vector; `pass`=0.
- Model with `dut_sum` inverted, macro undefined → `err_count` saturates at 255; `vec_count`=256. With macro defined → `done` after 3 cycles, `vec_count`=1, `fail_a`=0xA5, `fail_b`=0x00.
- Pulse `start` mid-run → ignored; run length is unchanged. Assert `rst` at cycle 100 → all outputs 0 next cycle; a fresh start then completes normally.
- Golden model with `LAT`=4, `NUM_VECTORS`=10 → `done` after 60 cycles, `pass`=1, `vec_count`=10.
